// File: rtl/riscv_pipe_pkg.sv
// Shared types for the elastic pipeline-stage register and its users.
package riscv_pipe_pkg;

  // Occupancy state of the stage; encoding equals the number of held entries.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_t;

  // Width of the occupancy count output.
  localparam int PIPE_COUNT_W = 2;
  typedef logic [PIPE_COUNT_W-1:0] pipe_count_t;

  // Example stage control bundle (EX/MEM), packed into CTRL_W at the instantiation site.
  typedef struct packed {
    logic       regw;
    logic [1:0] resultsrc;
    logic       memw;
    logic       trap;
    logic       csr_we;
    logic [9:0] rsvd;
  } ex_mem_ctrl_t;

  // Number of valid entries held in a given state.
  function automatic pipe_count_t count_of(input pipe_state_t s);
    return pipe_count_t'(s);
  endfunction

endpackage

// File: rtl/riscv_pipe_slot.sv
// One payload register (data + ctrl) with load and clear enables.
// Clear wins over load; ctrl is always zeroed on clear, data only if FLUSH_DATA=1.
module riscv_pipe_slot #(
  parameter int DATA_W     = 64,
  parameter int CTRL_W     = 16,
  parameter bit FLUSH_DATA = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] next_data,
  input  logic [CTRL_W-1:0] next_ctrl,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);

  // Payload register: clear has priority, otherwise load captures the new beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= '0;
      ctrl <= '0;
    end else if (clear) begin
      ctrl <= '0;
      if (FLUSH_DATA) data <= '0;
    end else if (load) begin
      data <= next_data;
      ctrl <= next_ctrl;
    end
  end

endmodule

// File: rtl/riscv_pipe_skidreg.sv
// Elastic pipeline-stage register with a 2-entry skid buffer.
// Handshake: a beat transfers on a rising edge where valid and ready are both 1;
// once valid is raised with a payload, the payload stays stable until it transfers
// or is flushed. Upstream ready depends only on registered state, so no
// combinational path runs from downstream ready to upstream ready.
module riscv_pipe_skidreg
  import riscv_pipe_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int CTRL_W     = 16,
  parameter bit FLUSH_DATA = 1'b1
) (
  input  logic              i_riscv_pipe_clk,
  input  logic              i_riscv_pipe_rst,
  input  logic              i_riscv_pipe_valid,
  output logic              o_riscv_pipe_ready,
  input  logic [DATA_W-1:0] i_riscv_pipe_data,
  input  logic [CTRL_W-1:0] i_riscv_pipe_ctrl,
  output logic              o_riscv_pipe_valid,
  input  logic              i_riscv_pipe_ready,
  output logic [DATA_W-1:0] o_riscv_pipe_data,
  output logic [CTRL_W-1:0] o_riscv_pipe_ctrl,
  input  logic              i_riscv_pipe_flush,
  output logic [1:0]        o_riscv_pipe_count
);

  pipe_state_t       state, state_nxt;
  logic              up_xfer, dn_xfer;
  logic              main_load, main_from_skid, skid_load;
  logic [DATA_W-1:0] skid_data, main_next_data;
  logic [CTRL_W-1:0] skid_ctrl, main_next_ctrl;

  // State-derived outputs: main valid whenever not EMPTY, skid valid only in TWO.
  assign o_riscv_pipe_valid = (state != EMPTY);
  assign o_riscv_pipe_ready = (state != TWO);
  assign o_riscv_pipe_count = count_of(state);

  assign up_xfer = i_riscv_pipe_valid & o_riscv_pipe_ready;
  assign dn_xfer = o_riscv_pipe_valid & i_riscv_pipe_ready;

  // State register.
  always_ff @(posedge i_riscv_pipe_clk or posedge i_riscv_pipe_rst) begin
    if (i_riscv_pipe_rst) state <= EMPTY;
    else                  state <= state_nxt;
  end

  // Next-state logic; flush overrides every handshake.
  always_comb begin
    state_nxt = state;
    if (i_riscv_pipe_flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY:   if (up_xfer) state_nxt = ONE;
        ONE:     if (up_xfer && !dn_xfer) state_nxt = TWO;
                 else if (!up_xfer && dn_xfer) state_nxt = EMPTY;
        TWO:     if (dn_xfer) state_nxt = ONE;
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Slot enables: which register captures which beat this cycle.
  always_comb begin
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    if (!i_riscv_pipe_flush) begin
      case (state)
        EMPTY: main_load = up_xfer;
        ONE: begin
          main_load = up_xfer & dn_xfer;
          skid_load = up_xfer & ~dn_xfer;
        end
        TWO: begin
          main_load      = dn_xfer;
          main_from_skid = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign main_next_data = main_from_skid ? skid_data : i_riscv_pipe_data;
  assign main_next_ctrl = main_from_skid ? skid_ctrl : i_riscv_pipe_ctrl;

  riscv_pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .FLUSH_DATA(FLUSH_DATA)) u_main (
    .clk       (i_riscv_pipe_clk),
    .rst       (i_riscv_pipe_rst),
    .load      (main_load),
    .clear     (i_riscv_pipe_flush),
    .next_data (main_next_data),
    .next_ctrl (main_next_ctrl),
    .data      (o_riscv_pipe_data),
    .ctrl      (o_riscv_pipe_ctrl)
  );

  riscv_pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .FLUSH_DATA(FLUSH_DATA)) u_skid (
    .clk       (i_riscv_pipe_clk),
    .rst       (i_riscv_pipe_rst),
    .load      (skid_load),
    .clear     (i_riscv_pipe_flush),
    .next_data (i_riscv_pipe_data),
    .next_ctrl (i_riscv_pipe_ctrl),
    .data      (skid_data),
    .ctrl      (skid_ctrl)
  );

endmodule

// File: tb/tb_riscv_pipe_skidreg.sv
// Bench for riscv_pipe_skidreg: directed scenarios plus a random scoreboard run.
// Two instances share stimulus; u_hold has FLUSH_DATA=0.
module tb_riscv_pipe_skidreg;

  localparam int DATA_W = 64;
  localparam int CTRL_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, out_ready, flush;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              up_ready, out_valid, h_ready, h_valid;
  logic [DATA_W-1:0] out_data, h_data;
  logic [CTRL_W-1:0] out_ctrl, h_ctrl;
  logic [1:0]        count, h_count;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] exp_q[$];
  logic [CTRL_W-1:0] exp_ctrl_q[$];

  // Clock / reset
  always #5 clk = ~clk;

  riscv_pipe_skidreg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .FLUSH_DATA(1'b1)) dut (
    .i_riscv_pipe_clk   (clk),
    .i_riscv_pipe_rst   (rst),
    .i_riscv_pipe_valid (in_valid),
    .o_riscv_pipe_ready (up_ready),
    .i_riscv_pipe_data  (in_data),
    .i_riscv_pipe_ctrl  (in_ctrl),
    .o_riscv_pipe_valid (out_valid),
    .i_riscv_pipe_ready (out_ready),
    .o_riscv_pipe_data  (out_data),
    .o_riscv_pipe_ctrl  (out_ctrl),
    .i_riscv_pipe_flush (flush),
    .o_riscv_pipe_count (count)
  );

  riscv_pipe_skidreg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .FLUSH_DATA(1'b0)) u_hold (
    .i_riscv_pipe_clk   (clk),
    .i_riscv_pipe_rst   (rst),
    .i_riscv_pipe_valid (in_valid),
    .o_riscv_pipe_ready (h_ready),
    .i_riscv_pipe_data  (in_data),
    .i_riscv_pipe_ctrl  (in_ctrl),
    .o_riscv_pipe_valid (h_valid),
    .i_riscv_pipe_ready (out_ready),
    .o_riscv_pipe_data  (h_data),
    .o_riscv_pipe_ctrl  (h_ctrl),
    .i_riscv_pipe_flush (flush),
    .o_riscv_pipe_count (h_count)
  );

  // Checker
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                       input logic r, input logic f);
    in_valid  = v;
    in_data   = d;
    in_ctrl   = c;
    out_ready = r;
    flush     = f;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic up, dn;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    rst = 1'b1;
    #3;
    check("rst_valid", out_valid, 0);
    check("rst_ready", up_ready, 1);
    check("rst_data", out_data, 0);
    check("rst_ctrl", out_ctrl, 0);
    check("rst_count", count, 0);
    #9 rst = 1'b0;

    // Streaming: 1,2,3,4 back to back with downstream always ready
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, DATA_W'(k), CTRL_W'(k), 1'b1, 1'b0);
      step();
      check("stream_valid", out_valid, 1);
      check("stream_data", out_data, k);
      check("stream_ctrl", out_ctrl, k);
      check("stream_count", count, 1);
      check("stream_ready", up_ready, 1);
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    step();
    check("stream_drain_valid", out_valid, 0);
    check("stream_drain_count", count, 0);

    // Backpressure: 0xA then 0xB into a stalled stage
    drive(1'b1, 64'hA, 16'h1, 1'b0, 1'b0);
    step();
    check("bp_count1", count, 1);
    drive(1'b1, 64'hB, 16'h2, 1'b0, 1'b0);
    step();
    check("bp_count2", count, 2);
    check("bp_ready0", up_ready, 0);
    check("bp_data_a", out_data, 64'hA);
    drive(1'b1, 64'hC, 16'h3, 1'b0, 1'b0);
    step();
    check("bp_hold_data", out_data, 64'hA);
    check("bp_hold_ctrl", out_ctrl, 16'h1);
    check("bp_no_accept", count, 2);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    step();
    check("bp_data_b", out_data, 64'hB);
    check("bp_ctrl_b", out_ctrl, 16'h2);
    check("bp_count_drain", count, 1);
    check("bp_ready_back", up_ready, 1);
    step();
    check("bp_empty_valid", out_valid, 0);
    check("bp_empty_count", count, 0);

    // Flush in TWO: payload zeroed (FLUSH_DATA=1) or held (FLUSH_DATA=0)
    drive(1'b1, 64'h1234, 16'h00FF, 1'b0, 1'b0);
    step();
    drive(1'b1, 64'h5678, 16'h00FF, 1'b0, 1'b0);
    step();
    check("fl_pre_count", count, 2);
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    step();
    check("fl_valid", out_valid, 0);
    check("fl_ctrl", out_ctrl, 0);
    check("fl_data_zero", out_data, 0);
    check("fl_count", count, 0);
    check("fl_ready", up_ready, 1);
    check("fl_hold_data", h_data, 64'h1234);
    check("fl_hold_ctrl", h_ctrl, 0);
    check("fl_hold_valid", h_valid, 0);

    // Flush with a simultaneous upstream beat: beat dropped
    drive(1'b1, 64'h55, 16'h5, 1'b1, 1'b1);
    step();
    check("fl_drop_valid", out_valid, 0);
    check("fl_drop_count", count, 0);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      step();
      check("fl_drop_idle", out_valid, 0);
    end
    drive(1'b1, 64'h66, 16'h6, 1'b1, 1'b0);
    step();
    check("fl_next_valid", out_valid, 1);
    check("fl_next_data", out_data, 64'h66);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    step();

    // Asynchronous reset mid-cycle in ONE
    drive(1'b1, 64'h99, 16'h1, 1'b0, 1'b0);
    step();
    check("ar_pre_valid", out_valid, 1);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("ar_valid", out_valid, 0);
    check("ar_data", out_data, 0);
    check("ar_ctrl", out_ctrl, 0);
    check("ar_count", count, 0);
    #2 rst = 1'b0;
    drive(1'b1, 64'h7, 16'h7, 1'b1, 1'b0);
    step();
    check("ar_first_valid", out_valid, 1);
    check("ar_first_data", out_data, 64'h7);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    step();
    check("ar_drained", count, 0);

    // Random valid/ready with sparse flush against a queue model
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 1)), {$urandom, $urandom}, CTRL_W'($urandom),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
      up = in_valid & up_ready;
      dn = out_valid & out_ready;
      step();
      if (dn && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        void'(exp_ctrl_q.pop_front());
      end
      if (flush) begin
        exp_q.delete();
        exp_ctrl_q.delete();
      end else if (up) begin
        exp_q.push_back(in_data);
        exp_ctrl_q.push_back(in_ctrl);
      end
      check("rnd_valid", out_valid, exp_q.size() != 0);
      check("rnd_count", count, exp_q.size());
      check("rnd_ready", up_ready, exp_q.size() < 2);
      if (exp_q.size() != 0) begin
        check("rnd_data", out_data, exp_q[0]);
        check("rnd_ctrl", out_ctrl, exp_ctrl_q[0]);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_pipe_skidreg.md
Name: riscv_pipe_skidreg

Overview:
- Parametrised, elastic pipeline-stage register that replaces fixed-field, enable-only stage registers between pipeline stages.
- Carries an opaque data payload and a control payload with a valid/ready handshake.
- Uses a 2-entry skid buffer, so upstream ready is registered and breaks the combinational ready path.
- Flush clears the control payload and valid state; this turns in-flight beats into bubbles, for example on a trap.

Parameters:
- DATA_W, 64: width of data payload (result, pc, immediates, csr data, concatenated).
- CTRL_W, 16: width of control payload (regw, resultsrc, trap/csr flags). Forced to 0 on flush.
- FLUSH_DATA, 1: 1 = data payload also zeroed on flush; 0 = data payload held on flush.

Ports:
- i_riscv_pipe_clk  in  1  clock, rising edge.
- i_riscv_pipe_rst  in  1  asynchronous, active-high reset.
- i_riscv_pipe_valid  in  1  upstream beat valid.
- o_riscv_pipe_ready  out  1  upstream may transfer. Registered.
- i_riscv_pipe_data  in  DATA_W  upstream data payload.
- i_riscv_pipe_ctrl  in  CTRL_W  upstream control payload.
- o_riscv_pipe_valid  out  1  downstream beat valid.
- i_riscv_pipe_ready  in  1  downstream accepts.
- o_riscv_pipe_data  out  DATA_W  downstream data payload.
- o_riscv_pipe_ctrl  out  CTRL_W  downstream control payload.
- i_riscv_pipe_flush  in  1  synchronous flush.
- o_riscv_pipe_count  out  2  entries held (0..2).

Behaviour:
- Clock and reset: one clock (i_riscv_pipe_clk). Reset i_riscv_pipe_rst is asynchronous and active-high.
- Reset values:
  - o_valid=0, o_ready=1, o_data=0, o_ctrl=0, o_count=0.
  - Skid entry valid=0, skid data=0, skid ctrl=0.
  - Reset mid-transfer discards all beats immediately, without waiting for a clock edge.
- Handshakes:
  - Upstream transfer: i_valid & o_ready at a rising edge.
  - Downstream transfer: o_valid & i_ready at a rising edge.
  - While o_valid=1 and i_ready=0, o_data and o_ctrl are held stable (no change until accepted or flushed).
- Storage: main register (drives outputs) plus skid register. o_ready = !skid_valid, registered.
- States:
  - EMPTY (count 0)
  - ONE (main valid)
  - TWO (main and skid valid; o_ready=0)
- Transitions, with in = upstream transfer and out = downstream transfer:
  - EMPTY, in: load main -> ONE. Latency 1 cycle from accept to o_valid.
  - ONE, in & out: load main with the new beat -> ONE. Full throughput, 1 beat/cycle.
  - ONE, in & !out: load skid with the new beat -> TWO.
  - ONE, !in & out -> EMPTY.
  - TWO, out: main <= skid; skid cleared -> ONE. No upstream accept is possible in TWO.
  - All other cases: hold.
- Ordering: strict FIFO; the skid beat is never emitted before the main beat.
- Flush (priority over every handshake):
  - At the edge: main and skid valid cleared; both ctrl fields zeroed.
  - Data zeroed if FLUSH_DATA=1, otherwise held.
  - o_ready returns to 1 and count to 0.
  - An upstream beat presented in the flush cycle is dropped, even if o_ready=1.
  - A downstream transfer in the flush cycle still counts as completed from downstream's view. The register does not re-emit that beat.
- Count: o_count equals main_valid + skid_valid, registered.
- Invariants:
  - skid_valid implies main_valid.
  - count never exceeds 2.
  - No beat is duplicated or lost except by flush.
- No arithmetic beyond the 2-bit count; payload widths are passed through unmodified.

Decomposition:
- Shared package riscv_pipe_pkg: state enum {EMPTY, ONE, TWO} and the typedef for count width. Stage-specific ctrl struct typedefs also live there, for packing into CTRL_W at instantiation sites.
- Sub-module riscv_pipe_slot: one payload register with load/clear enables, instantiated twice (main, skid). Keeps the control FSM in the top.

Test Plan:
- Streaming: i_ready=1, i_valid=1, data=1,2,3,4 on consecutive cycles -> outputs 1,2,3,4 one cycle later, one per cycle; count stays 1; o_ready stays 1.
- Backpressure: send 0xA, 0xB with i_ready=0 -> count=2, o_ready=0, o_data holds 0xA. Then raise i_ready -> outputs 0xA then 0xB, then count=0, and o_ready=1 one cycle after the skid drains.
- Flush in TWO state: ctrl=0x00FF, data=0x1234 stalled, assert flush -> next cycle o_valid=0, o_ctrl=0, o_data=0 (FLUSH_DATA=1), count=0, o_ready=1. Repeat with FLUSH_DATA=0 -> o_data=0x1234 held.
- Flush with simultaneous upstream beat 0x55 and o_ready=1 -> beat dropped, o_valid=0 for the following cycles, until a new transfer occurs.
- Asynchronous reset asserted mid-cycle in state ONE -> o_valid, o_ctrl, o_data and count go to 0 before the next clock edge. After reset deasserts, a first beat 0x7 appears one cycle after its accept.
- Random valid/ready plus sparse flush, checked with a scoreboard -> order preserved, no duplicates, data stable while stalled, count never exceeds 2.
